// File: rtl/ewb_mem_arbiter.sv
// Memory-port arbiter for the L2 eviction write buffer: grants line-fill reads or EWB drains,
// serialises/assembles 64-bit beats and pops the EWB head only after its burst completes.
`timescale 1ns/1ps
module ewb_mem_arbiter #(
   parameter int unsigned DATA_W          = 256,
   parameter int unsigned BEAT_W          = 64,
   parameter int unsigned MAX_READ_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              l2_read_i,
   input  logic [31:0]       l2_addr_i,
   output logic [DATA_W-1:0] l2_rdata_o,
   output logic              l2_resp_o,
   input  logic              ewb_empty_i,
   input  logic              ewb_full_i,
   input  logic [DATA_W-1:0] ewb_data_i,
   input  logic [31:0]       ewb_addr_i,
   output logic              ewb_yumi_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [BEAT_W-1:0] mem_burst_o,
   input  logic [BEAT_W-1:0] mem_burst_i,
   input  logic              mem_resp_i
);

   localparam int unsigned BEATS      = DATA_W / BEAT_W;
   localparam int unsigned BEAT_CNT_W = $clog2(BEATS);
   localparam int unsigned STREAK_W   = $clog2(MAX_READ_STREAK + 1);
   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);
   localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_READ_STREAK);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_DONE,
      WR,
      WR_DONE
   } state_e;

   state_e                    state_q, state_d;
   logic [STREAK_W-1:0]       streak_q;
   logic [BEAT_CNT_W-1:0]     beat_q;
   logic [31:0]               addr_q;
   logic [DATA_W-1:0]         wr_line_q;
   logic [DATA_W-BEAT_W-1:0]  asm_q;
   logic [DATA_W-1:0]         rdata_q;
   logic                      grant_rd, grant_wr;
   logic                      beat_xfer;

   assign beat_xfer = ((state_q == RD) || (state_q == WR)) && mem_resp_i;

   always_comb begin
      state_d  = state_q;
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      case (state_q)
         IDLE: begin
            // A full EWB outranks fills; otherwise fills win until the streak limit.
            if (ewb_full_i && !ewb_empty_i)                  grant_wr = 1'b1;
            else if (l2_read_i && (streak_q < STREAK_MAX))   grant_rd = 1'b1;
            else if (!ewb_empty_i)                           grant_wr = 1'b1;
            else if (l2_read_i)                              grant_rd = 1'b1;
            if (grant_wr) state_d = WR;
            if (grant_rd) state_d = RD;
         end
         RD:      if (mem_resp_i && (beat_q == LAST_BEAT)) state_d = RD_DONE;
         RD_DONE: state_d = IDLE;
         WR:      if (mem_resp_i && (beat_q == LAST_BEAT)) state_d = WR_DONE;
         WR_DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         streak_q  <= '0;
         beat_q    <= '0;
         addr_q    <= '0;
         wr_line_q <= '0;
         asm_q     <= '0;
         rdata_q   <= '0;
      end else begin
         state_q <= state_d;
         if (grant_wr) begin
            addr_q    <= ewb_addr_i & ~32'h1F;
            wr_line_q <= ewb_data_i;
            streak_q  <= '0;
         end
         if (grant_rd) begin
            addr_q <= l2_addr_i & ~32'h1F;
            if (ewb_empty_i)                streak_q <= '0;
            else if (streak_q < STREAK_MAX) streak_q <= streak_q + STREAK_W'(1);
         end
         if (beat_xfer) beat_q <= beat_q + BEAT_CNT_W'(1);
         // Assemble into a side buffer so l2_rdata_o only changes when a fill completes.
         if ((state_q == RD) && mem_resp_i) begin
            if (beat_q == LAST_BEAT) begin
               rdata_q <= {mem_burst_i, asm_q};
            end else begin
               for (int k = 0; k < BEATS - 1; k++) begin
                  if (beat_q == BEAT_CNT_W'(k)) asm_q[k*BEAT_W +: BEAT_W] <= mem_burst_i;
               end
            end
         end
      end
   end

   always_comb begin
      mem_burst_o = '0;
      if (state_q == WR) begin
         for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_CNT_W'(k)) mem_burst_o = wr_line_q[k*BEAT_W +: BEAT_W];
         end
      end
   end

   assign mem_read_o  = (state_q == RD);
   assign mem_write_o = (state_q == WR);
   assign l2_resp_o   = (state_q == RD_DONE);
   assign ewb_yumi_o  = (state_q == WR_DONE);
   assign mem_addr_o  = addr_q;
   assign l2_rdata_o  = rdata_q;

endmodule

// File: tb/tb_ewb_mem_arbiter.sv
// Directed bench for ewb_mem_arbiter: vector table of single reads/drains plus
// hand-written sequences for priority, starvation bound, mid-burst reset and stray responses.
`timescale 1ns/1ps
module tb_ewb_mem_arbiter;

   localparam logic [255:0] L0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] L1 = {64'hD0D1_D2D3_D4D5_D6D7, 64'hC0C1_C2C3_C4C5_C6C7,
                                  64'hB0B1_B2B3_B4B5_B6B7, 64'hA0A1_A2A3_A4A5_A6A7};
   localparam logic [255:0] L2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                  64'h5555_AAAA_5555_AAAA, 64'hDEAD_BEEF_CAFE_F00D};
   localparam logic [255:0] L3 = {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE,
                                  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};

   logic         clk = 1'b0;
   logic         rst;
   logic         l2_read_i;
   logic [31:0]  l2_addr_i;
   logic [255:0] l2_rdata_o;
   logic         l2_resp_o;
   logic         ewb_empty_i;
   logic         ewb_full_i;
   logic [255:0] ewb_data_i;
   logic [31:0]  ewb_addr_i;
   logic         ewb_yumi_o;
   logic         mem_read_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [63:0]  mem_burst_o;
   logic [63:0]  mem_burst_i;
   logic         mem_resp_i;

   int n_cmp = 0;
   int n_bad = 0;
   logic [255:0] last_rd;

   typedef struct {
      bit           is_wr;
      logic [31:0]  addr;
      logic [255:0] line;
      logic [3:0]   stall;
      logic [31:0]  exp_addr;
   } vec_t;

   vec_t vec [5];

   ewb_mem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .l2_read_i   (l2_read_i),
      .l2_addr_i   (l2_addr_i),
      .l2_rdata_o  (l2_rdata_o),
      .l2_resp_o   (l2_resp_o),
      .ewb_empty_i (ewb_empty_i),
      .ewb_full_i  (ewb_full_i),
      .ewb_data_i  (ewb_data_i),
      .ewb_addr_i  (ewb_addr_i),
      .ewb_yumi_o  (ewb_yumi_o),
      .mem_read_o  (mem_read_o),
      .mem_write_o (mem_write_o),
      .mem_addr_o  (mem_addr_o),
      .mem_burst_o (mem_burst_o),
      .mem_burst_i (mem_burst_i),
      .mem_resp_i  (mem_resp_i)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chkv(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Entered at the negedge where the grant must be visible; returns at the done-pulse negedge.
   task automatic run_burst(input bit is_wr, input logic [255:0] line,
                            input logic [31:0] exp_addr, input logic [3:0] stall);
      chk1("grant_rd", mem_read_o, !is_wr);
      chk1("grant_wr", mem_write_o, is_wr);
      chkv("mem_addr", 256'(mem_addr_o), 256'(exp_addr));
      for (int k = 0; k < 4; k++) begin
         if (stall[k]) begin
            mem_resp_i = 1'b0;
            @(negedge clk);
            chk1("stall_busy", is_wr ? mem_write_o : mem_read_o, 1'b1);
         end
         if (is_wr) chkv("wr_beat", 256'(mem_burst_o), 256'(line[k*64 +: 64]));
         chk1("rd_wr_both", mem_read_o & mem_write_o, 1'b0);
         chk1("early_done", is_wr ? ewb_yumi_o : l2_resp_o, 1'b0);
         mem_resp_i  = 1'b1;
         mem_burst_i = line[k*64 +: 64];
         @(negedge clk);
      end
      mem_resp_i  = 1'b0;
      mem_burst_i = '0;
      chk1("done_pulse", is_wr ? ewb_yumi_o : l2_resp_o, 1'b1);
      chk1("other_pulse", is_wr ? l2_resp_o : ewb_yumi_o, 1'b0);
      chk1("busy_dropped", mem_read_o | mem_write_o, 1'b0);
      if (!is_wr) begin
         chkv("rdata", l2_rdata_o, line);
         last_rd = line;
      end
   endtask

   initial begin
      vec[0] = '{1'b0, 32'h0000_1234, L0, 4'b0000, 32'h0000_1220};
      vec[1] = '{1'b1, 32'h8000_0040, L1, 4'b1110, 32'h8000_0040};
      vec[2] = '{1'b0, 32'hDEAD_BEEF, L2, 4'b0101, 32'hDEAD_BEE0};
      vec[3] = '{1'b1, 32'h1234_567F, L3, 4'b0000, 32'h1234_5660};
      vec[4] = '{1'b0, 32'hFFFF_FFFF, L3, 4'b1111, 32'hFFFF_FFE0};

      rst = 1'b0; l2_read_i = 1'b0; l2_addr_i = '0; ewb_empty_i = 1'b1; ewb_full_i = 1'b0;
      ewb_data_i = '0; ewb_addr_i = '0; mem_burst_i = '0; mem_resp_i = 1'b0; last_rd = '0;
      #1 rst = 1'b1;
      #1;
      chk1("rst_mem_read", mem_read_o, 1'b0);
      chk1("rst_mem_write", mem_write_o, 1'b0);
      chk1("rst_resp", l2_resp_o, 1'b0);
      chk1("rst_yumi", ewb_yumi_o, 1'b0);
      chkv("rst_addr", 256'(mem_addr_o), '0);
      chkv("rst_burst", 256'(mem_burst_o), '0);
      chkv("rst_rdata", l2_rdata_o, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Stray responses in IDLE must not move state or the beat counter.
      for (int i = 0; i < 3; i++) begin
         mem_resp_i  = 1'b1;
         mem_burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
         @(negedge clk);
         chk1("spur_read", mem_read_o, 1'b0);
         chk1("spur_write", mem_write_o, 1'b0);
         chk1("spur_pulse", l2_resp_o | ewb_yumi_o, 1'b0);
         chkv("spur_rdata", l2_rdata_o, '0);
      end
      mem_resp_i = 1'b0;
      mem_burst_i = '0;

      // Table: single reads (EWB empty) and drains (no read pending).
      for (int i = 0; i < 5; i++) begin
         if (vec[i].is_wr) begin
            ewb_empty_i = 1'b0; ewb_full_i = 1'b0;
            ewb_addr_i  = vec[i].addr; ewb_data_i = vec[i].line; l2_read_i = 1'b0;
         end else begin
            ewb_empty_i = 1'b1; l2_read_i = 1'b1; l2_addr_i = vec[i].addr;
         end
         @(negedge clk);
         run_burst(vec[i].is_wr, vec[i].line, vec[i].exp_addr, vec[i].stall);
         if (vec[i].is_wr) begin
            ewb_empty_i = 1'b1;
            chkv("rdata_hold", l2_rdata_o, last_rd);
         end else begin
            l2_read_i = 1'b0;
         end
         @(negedge clk);
         chk1("pulse_once", l2_resp_o | ewb_yumi_o, 1'b0);
         chk1("idle_quiet", mem_read_o | mem_write_o, 1'b0);
      end

      // Full EWB beats a simultaneous fill; the fill follows the pop.
      ewb_full_i = 1'b1; ewb_empty_i = 1'b0; ewb_addr_i = 32'h0000_2000; ewb_data_i = L2;
      l2_read_i = 1'b1; l2_addr_i = 32'h0000_3000;
      @(negedge clk);
      run_burst(1'b1, L2, 32'h0000_2000, 4'b0000);
      ewb_full_i = 1'b0; ewb_empty_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      run_burst(1'b0, L0, 32'h0000_3000, 4'b0000);
      l2_read_i = 1'b0;
      @(negedge clk);

      // Starvation bound: four fills, one drain, then fills resume.
      ewb_empty_i = 1'b0; ewb_full_i = 1'b0; ewb_addr_i = 32'h4000_0000; ewb_data_i = L1;
      l2_read_i = 1'b1; l2_addr_i = 32'h0000_5000;
      @(negedge clk);
      for (int r = 0; r < 4; r++) begin
         run_burst(1'b0, L0, 32'h0000_5000, 4'b0000);
         @(negedge clk);
         chk1("streak_resp_once", l2_resp_o, 1'b0);
         @(negedge clk);
      end
      run_burst(1'b1, L1, 32'h4000_0000, 4'b0000);
      ewb_addr_i = 32'h4000_0020; ewb_data_i = L3;
      @(negedge clk);
      @(negedge clk);
      run_burst(1'b0, L2, 32'h0000_5000, 4'b0000);
      l2_read_i = 1'b0; ewb_empty_i = 1'b1;
      @(negedge clk);

      // Async reset after three beats of a drain, then the same head drains cleanly.
      ewb_empty_i = 1'b0; ewb_addr_i = 32'h8000_0040; ewb_data_i = L1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chkv("pre_rst_beat", 256'(mem_burst_o), 256'(L1[k*64 +: 64]));
         mem_resp_i = 1'b1;
         @(negedge clk);
      end
      mem_resp_i = 1'b0;
      rst = 1'b1;
      #1;
      chk1("arst_write", mem_write_o, 1'b0);
      chk1("arst_read", mem_read_o, 1'b0);
      chk1("arst_yumi", ewb_yumi_o, 1'b0);
      chk1("arst_resp", l2_resp_o, 1'b0);
      chkv("arst_addr", 256'(mem_addr_o), '0);
      chkv("arst_burst", 256'(mem_burst_o), '0);
      chkv("arst_rdata", l2_rdata_o, '0);
      @(negedge clk);
      chk1("arst_no_yumi", ewb_yumi_o, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      run_burst(1'b1, L1, 32'h8000_0040, 4'b0000);
      ewb_empty_i = 1'b1;
      @(negedge clk);
      chk1("post_rst_yumi_once", ewb_yumi_o, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ewb_mem_arbiter.md
# ewb_mem_arbiter

Downstream stage of the L2 eviction write buffer. Arbitrates the single physical-memory burst port between L2 line-fill reads and EWB drain writes. Serialises 256-bit lines into 64-bit beats, assembles read beats back into lines, and pops the EWB head only after its writeback completes. Keeping the entry in the buffer until then leaves the EWB tag-check path valid for the line in flight.

## Interface
- width, 256, cache line width in bits
- beat, 64, memory burst width in bits; beats = width/beat = 4
- max_read_streak, 4, consecutive read grants allowed while EWB non-empty

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- l2_read_i  in  1  L2 line-fill request, level, held until l2_resp_o
- l2_addr_i  in  32  fill address; low 5 bits ignored
- l2_rdata_o  out  width  assembled fill line, valid with l2_resp_o
- l2_resp_o  out  1  one-cycle fill-complete pulse
- ewb_empty_i  in  1  EWB empty
- ewb_full_i  in  1  EWB full
- ewb_data_i  in  width  EWB head line
- ewb_addr_i  in  32  EWB head address
- ewb_yumi_o  out  1  one-cycle pop of the EWB head
- mem_read_o  out  1  burst read, held for the whole burst
- mem_write_o  out  1  burst write, held for the whole burst
- mem_addr_o  out  32  line-aligned burst address; [4:0] = 0
- mem_burst_o  out  beat  write beat data
- mem_burst_i  in  beat  read beat data
- mem_resp_i  in  1  per-beat handshake; one beat transferred per high cycle

## Operation
- States: IDLE, RD, RD_DONE, WR, WR_DONE.
- IDLE grant priority, evaluated each cycle:
  1. ewb_full_i && !ewb_empty_i -> WR
  2. l2_read_i && streak < max_read_streak -> RD
  3. !ewb_empty_i -> WR
  4. l2_read_i -> RD. This covers streak saturated with the EWB empty.
- streak counter:
  - Increments on each RD grant made while ewb_empty_i = 0.
  - Clears on every WR grant, and on any RD grant with ewb_empty_i = 1.
  - Saturates at max_read_streak.
- On a WR grant, latch ewb_addr_i & ~32'h1F and ewb_data_i. On an RD grant, latch l2_addr_i & ~32'h1F.
- RD:
  - mem_read_o = 1.
  - Beat counter 0..3 advances on mem_resp_i.
  - Beat k is stored in line bits [64k+63:64k].
  - After beat 3 is captured -> RD_DONE.
- RD_DONE:
  - l2_resp_o = 1 and l2_rdata_o is valid, for one cycle.
  - l2_read_i is ignored this cycle. -> IDLE.
- WR:
  - mem_write_o = 1, mem_burst_o = latched line bits [64k+63:64k] for current beat k.
  - Beat k advances on mem_resp_i. After beat 3 -> WR_DONE.
- WR_DONE: ewb_yumi_o = 1 for one cycle. -> IDLE.
- The EWB head is never popped before all 4 beats are acknowledged.
- mem_read_o and mem_write_o are never high together.
- mem_resp_i outside RD/WR is ignored.
- Beat counter is 2 bits and wraps 3 -> 0 on the last beat.

## Timing
- All outputs are registered or decoded from state only. No combinational input-to-output path.
- Reset values:
  - state = IDLE; streak and beat counter = 0.
  - All control outputs = 0; l2_rdata_o, mem_addr_o and mem_burst_o = 0.
- Grant: request seen in IDLE at cycle t -> mem_read_o or mem_write_o high at cycle t+1.
- Minimum read latency, with mem_resp_i high t+1..t+4: l2_resp_o at t+5. Each memory stall cycle adds one.
- Minimum write: ewb_yumi_o at t+5. Next grant is evaluated at t+6.
- l2_rdata_o holds its value until the next RD_DONE.
- Async rst mid-burst:
  - Returns to IDLE immediately and drops mem_read_o and mem_write_o.
  - No yumi or resp is issued.
  - The memory model is reset by the same rst.

## Test plan
- Read alone:
  - Stimulus: EWB empty, l2_read_i at 0x0000_1234; mem_resp_i 4 cycles with beats 0x11.., 0x22.., 0x33.., 0x44...
  - Required: mem_addr_o = 0x0000_1220, l2_resp_o 5 cycles after request, l2_rdata_o[63:0] = 0x11.. and [255:192] = 0x44...
- Drain alone:
  - Stimulus: EWB head addr 0x8000_0040 with a known 256-bit pattern; mem_resp_i stalled one cycle between beats.
  - Required: 4 beats appear low-to-high on mem_burst_o, ewb_yumi_o pulses once after the 4th beat, never earlier.
- Full priority:
  - Stimulus: ewb_full_i = 1 and l2_read_i = 1 in the same cycle.
  - Required: WR granted first; the read completes after the following ewb_yumi_o.
- Starvation bound:
  - Stimulus: back-to-back reads with EWB non-empty, not full.
  - Required: exactly 4 reads served, then one write, then reads resume.
- Reset mid-burst:
  - Stimulus: assert rst after beat 2 of a write.
  - Required: all outputs 0 the same cycle, no ewb_yumi_o; a fresh write of the same head afterwards completes normally.
- Spurious mem_resp_i in IDLE:
  - Required: no state or counter change.
